// File: rtl/eth_pkg.sv
// Shared types, constants and the reflected CRC-32 byte step for the Ethernet TX framer.
package eth_pkg;

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} tx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam int          PREAMBLE_BYTES  = 7;
  localparam int          FCS_BYTES       = 4;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 accumulator; one byte per enabled cycle, clear has priority.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic [7:0]  i_data_in,
  output logic [31:0] o_crc_out
);

  logic [31:0] r_crc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clear) r_crc <= CRC32_INIT;
    else if (i_enable)  r_crc <= crc32_byte(r_crc, i_data_in);
  end

  assign o_crc_out = r_crc;

endmodule

// File: rtl/rgmii_tx_framer.sv
// GMII/MII transmit framer: preamble, SFD, payload, zero pad, FCS and IFG with underrun abort.
module rgmii_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12,
  parameter bit ADD_FCS   = 1'b1
) (
  input  logic       gmii_txc,
  input  logic       rst,
  input  logic       mii_mode,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic       gmii_txen,
  output logic       gmii_txer,
  output logic [7:0] gmii_txd,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       underrun
);

  tx_state_e   r_state;
  logic        r_phase;
  logic        r_mii;
  logic [7:0]  r_cnt;
  logic [15:0] r_byte_cnt;
  logic        r_tlast_seen;
  logic        r_abort;
  logic [7:0]  r_data;
  logic        r_txen;
  logic        r_txer;
  logic [7:0]  r_txd;
  logic        r_frame_done;
  logic        r_underrun;

  tx_state_e   w_cur;
  logic        w_start;
  logic        w_mii;
  logic        w_slot_end;
  logic        w_accept;
  logic        w_starved;
  logic [7:0]  w_byte;
  logic [3:0]  w_nib;
  logic        w_txen;
  logic        w_txer;
  logic [15:0] w_byte_cnt_inc;
  logic        w_crc_en;
  logic        w_crc_clr;
  logic [31:0] w_crc;
  logic [31:0] w_fcs;

  // IDLE with a pending byte behaves as the first preamble cycle, so txen rises one cycle later.
  assign w_start    = (r_state == IDLE) && s_tvalid;
  assign w_cur      = w_start ? PREAMBLE : r_state;
  assign w_mii      = (r_state == IDLE) ? mii_mode : r_mii;
  assign w_slot_end = !w_mii || r_phase;

  assign s_tready  = w_slot_end &&
                     ((r_state == SFD) || ((r_state == DATA) && !r_tlast_seen && !r_abort));
  assign w_accept  = s_tready && s_tvalid;
  assign w_starved = s_tready && !s_tvalid;

  assign w_fcs = ~w_crc;

  always_comb begin
    // NOTE: default assigned before the case so no path leaves w_byte unassigned (no latch).
    w_byte = 8'h00;
    case (w_cur)
      PREAMBLE: w_byte = ETH_PREAMBLE;
      SFD:      w_byte = ETH_SFD;
      DATA:     w_byte = r_abort ? 8'h00 : r_data;
      FCS:      w_byte = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
      default:  w_byte = 8'h00;
    endcase
  end

  assign w_nib  = r_phase ? w_byte[7:4] : w_byte[3:0];
  assign w_txen = (w_cur != IDLE) && (w_cur != IFG);
  assign w_txer = (w_cur == DATA) && r_abort;

  assign w_byte_cnt_inc = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;

  // CRC advances on the last cycle of each payload/pad slot, so it is settled when FCS starts.
  assign w_crc_en  = w_slot_end && (((r_state == DATA) && !r_abort) || (r_state == PAD));
  assign w_crc_clr = (r_state == IDLE) || r_abort;

  eth_crc32 u_crc (
    .clk       (gmii_txc),
    .rst       (rst),
    .i_clear   (w_crc_clr),
    .i_enable  (w_crc_en),
    .i_data_in (w_byte),
    .o_crc_out (w_crc)
  );

  always_ff @(posedge gmii_txc) begin
    if (rst) begin
      r_state      <= IDLE;
      r_phase      <= 1'b0;
      r_mii        <= 1'b0;
      r_cnt        <= 8'd0;
      r_byte_cnt   <= 16'd0;
      r_tlast_seen <= 1'b0;
      r_abort      <= 1'b0;
      r_data       <= 8'h00;
      r_txen       <= 1'b0;
      r_txer       <= 1'b0;
      r_txd        <= 8'h00;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_txen       <= w_txen;
      r_txer       <= w_txer;
      r_txd        <= w_mii ? {4'h0, w_nib} : w_byte;

      if (w_accept) begin
        r_data       <= s_tdata;
        r_tlast_seen <= s_tlast;
      end
      if (w_start) r_mii <= mii_mode;

      if (w_cur != IDLE) begin
        r_state <= w_cur;
        if (!w_slot_end) begin
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          case (w_cur)
            PREAMBLE: begin
              if (r_cnt == 8'(PREAMBLE_BYTES - 1)) begin
                r_cnt   <= 8'd0;
                r_state <= SFD;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
            SFD: begin
              r_state <= DATA;
              if (w_starved) r_abort <= 1'b1;
            end
            DATA: begin
              if (r_abort) begin
                r_abort      <= 1'b0;
                r_tlast_seen <= 1'b0;
                r_underrun   <= 1'b1;
                r_byte_cnt   <= 16'd0;
                r_cnt        <= 8'd0;
                r_state      <= IFG;
              end else begin
                r_byte_cnt <= w_byte_cnt_inc;
                if (r_tlast_seen) begin
                  r_tlast_seen <= 1'b0;
                  r_cnt        <= 8'd0;
                  if (ADD_FCS && (w_byte_cnt_inc < 16'(MIN_FRAME))) begin
                    r_state <= PAD;
                  end else if (ADD_FCS) begin
                    r_state <= FCS;
                  end else begin
                    r_state      <= IFG;
                    r_frame_done <= 1'b1;
                  end
                end else if (w_starved) begin
                  r_abort <= 1'b1;
                end
              end
            end
            PAD: begin
              r_byte_cnt <= w_byte_cnt_inc;
              if (w_byte_cnt_inc >= 16'(MIN_FRAME)) r_state <= FCS;
            end
            FCS: begin
              if (r_cnt == 8'(FCS_BYTES - 1)) begin
                r_cnt        <= 8'd0;
                r_frame_done <= 1'b1;
                r_state      <= IFG;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
            IFG: begin
              if (r_cnt == 8'(IFG_BYTES - 1)) begin
                r_cnt      <= 8'd0;
                r_byte_cnt <= 16'd0;
                r_state    <= IDLE;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign gmii_txen  = r_txen;
  assign gmii_txer  = r_txer;
  assign gmii_txd   = r_txd;
  assign tx_busy    = (r_state != IDLE);
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Scoreboard bench for rgmii_tx_framer: expected wire slots are queued as frames are driven.
module tb_rgmii_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mii_mode = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic       gmii_txen, gmii_txer, tx_busy, frame_done, underrun;
  logic [7:0] gmii_txd;

  logic        crc_clr = 1'b0, crc_en = 1'b0;
  logic [7:0]  crc_din = 8'h00;
  logic [31:0] crc_out;

  always #4 clk = ~clk;

  rgmii_tx_framer dut (
    .gmii_txc   (clk),
    .rst        (rst),
    .mii_mode   (mii_mode),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .gmii_txen  (gmii_txen),
    .gmii_txer  (gmii_txer),
    .gmii_txd   (gmii_txd),
    .tx_busy    (tx_busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  eth_crc32 u_crc_chk (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (crc_clr),
    .i_enable  (crc_en),
    .i_data_in (crc_din),
    .o_crc_out (crc_out)
  );

  typedef struct packed {
    logic [7:0] txd;
    logic       er;
    logic       done;
    logic       urun;
  } exp_t;

  exp_t       exp_q[$];
  int         len_q[$];
  int         gap_q[$];
  logic [7:0] pay[$];
  int         n_vec = 0;
  int         n_miss = 0;
  bit         mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] b, input bit mii, input bit er, input bit done,
                           input bit urun, inout int len);
    if (mii) begin
      exp_q.push_back('{txd: {4'h0, b[3:0]}, er: er, done: 1'b0, urun: 1'b0});
      exp_q.push_back('{txd: {4'h0, b[7:4]}, er: er, done: done, urun: urun});
      len += 2;
    end else begin
      exp_q.push_back('{txd: b, er: er, done: done, urun: urun});
      len += 1;
    end
  endtask

  task automatic build_exp(input int n, input bit mii, input int drop_at, input int gap);
    logic [31:0] crc;
    int          len;
    len = 0;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) push_byte(8'h55, mii, 1'b0, 1'b0, 1'b0, len);
    push_byte(8'hD5, mii, 1'b0, 1'b0, 1'b0, len);
    if (drop_at >= 0) begin
      for (int i = 0; i < drop_at; i++) push_byte(pay[i], mii, 1'b0, 1'b0, 1'b0, len);
      push_byte(8'h00, mii, 1'b1, 1'b0, 1'b1, len);
    end else begin
      for (int i = 0; i < n; i++) begin
        crc = model_crc(crc, pay[i]);
        push_byte(pay[i], mii, 1'b0, 1'b0, 1'b0, len);
      end
      for (int i = n; i < 60; i++) begin
        crc = model_crc(crc, 8'h00);
        push_byte(8'h00, mii, 1'b0, 1'b0, 1'b0, len);
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) push_byte(crc[8*k +: 8], mii, 1'b0, k == 3, 1'b0, len);
    end
    len_q.push_back(len);
    gap_q.push_back(gap);
  endtask

  // Drives one frame through the valid/ready handshake; called at a falling edge.
  task automatic run_frame(input int n, input bit mii, input int drop_at, input int gap,
                           input logic [7:0] base);
    int idx, cyc;
    bit acc, flipped;
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(base + 8'(i));
    build_exp(n, mii, drop_at, gap);
    mii_mode = mii;
    flipped  = 1'b0;
    idx      = 0;
    cyc      = 0;
    s_tvalid = 1'b1;
    s_tdata  = pay[0];
    s_tlast  = (n == 1);
    while (idx < n && cyc < 5000) begin
      acc = s_tready;
      if (!mii && idx > 0) check("tready_stall", acc, 1);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (acc) begin
        idx++;
        if (idx == drop_at) break;
        if (idx < n) begin
          s_tdata = pay[idx];
          s_tlast = (idx == n - 1);
        end
        if (mii && !flipped && idx == n / 2) begin
          mii_mode = 1'b0;
          flipped  = 1'b1;
        end
      end
    end
    if (cyc >= 5000) check("accept_timeout", cyc, 0);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (drop_at >= 0 && idx == drop_at) begin
      cyc = 0;
      while (!s_tready && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 100) check("starve_timeout", cyc, 0);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || gmii_txen || tx_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("drain_timeout", t, 0);
    @(negedge clk);
    check("busy_after_drain", tx_busy, 0);
  endtask

  int   run_len = 0;
  int   idle_len = 0;
  logic prev_txen = 1'b0;

  always @(negedge clk) begin
    if (!mon_en) begin
      run_len   = 0;
      idle_len  = 0;
      prev_txen = 1'b0;
    end else begin
      if (gmii_txen) begin
        if (!prev_txen) begin
          if (gap_q.size() != 0) begin
            int g;
            g = gap_q.pop_front();
            if (g >= 0) check("ifg_gap", idle_len, g);
          end
          run_len = 0;
        end
        run_len++;
        if (exp_q.size() == 0) begin
          check("spurious_txen", gmii_txen, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("txd", gmii_txd, e.txd);
          check("txer", gmii_txer, e.er);
          check("frame_done", frame_done, e.done);
          check("underrun", underrun, e.urun);
        end
      end else begin
        if (prev_txen) begin
          if (len_q.size() != 0) check("txen_run", run_len, len_q.pop_front());
          idle_len = 0;
        end
        idle_len++;
        check("idle_out", {gmii_txer, gmii_txd, frame_done, underrun}, 0);
      end
      prev_txen = gmii_txen;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    string digits;
    digits = "123456789";

    repeat (3) @(negedge clk);
    check("rst_txen", gmii_txen, 0);
    check("rst_txer", gmii_txer, 0);
    check("rst_txd", gmii_txd, 0);
    check("rst_tready", s_tready, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    rst = 1'b0;

    crc_clr = 1'b1;
    @(negedge clk);
    crc_clr = 1'b0;
    check("crc_init", crc_out, 32'hFFFFFFFF);
    for (int i = 0; i < 9; i++) begin
      crc_din = digits[i];
      crc_en  = 1'b1;
      @(negedge clk);
    end
    crc_en = 1'b0;
    check("crc_check", ~crc_out, 32'hCBF43926);

    mon_en = 1'b1;
    run_frame(60, 1'b0, -1, -1, 8'h00);  drain();
    run_frame(10, 1'b0, -1, -1, 8'hA0);  drain();
    run_frame(60, 1'b1, -1, -1, 8'h00);  drain();
    run_frame(40, 1'b0, 20, -1, 8'h10);
    run_frame(16, 1'b0, -1, 12, 8'h40);  drain();
    run_frame(64, 1'b0, -1, -1, 8'h80);
    run_frame(64, 1'b0, -1, 12, 8'hC0);  drain();
    run_frame(1,  1'b0, -1, -1, 8'h5A);  drain();
    run_frame(20, 1'b1, 5,  -1, 8'h30);  drain();

    mon_en   = 1'b0;
    mii_mode = 1'b0;
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      s_tdata = 8'(i);
      @(negedge clk);
    end
    check("busy_mid_frame", tx_busy, 1);
    check("txen_mid_frame", gmii_txen, 1);
    rst      = 1'b1;
    s_tvalid = 1'b0;
    @(negedge clk);
    check("midrst_txen", gmii_txen, 0);
    check("midrst_txer", gmii_txer, 0);
    check("midrst_txd", gmii_txd, 0);
    check("midrst_tready", s_tready, 0);
    check("midrst_busy", tx_busy, 0);
    check("midrst_done", frame_done, 0);
    check("midrst_underrun", underrun, 0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_txen", gmii_txen, 0);
    exp_q.delete();
    len_q.delete();
    gap_q.delete();
    mon_en = 1'b1;
    run_frame(12, 1'b0, -1, -1, 8'h22);  drain();

    check("exp_left", exp_q.size(), 0);
    check("len_left", len_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
